// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: sync/deglitch, 11-bit frame deserializer, E0/F0 prefix folding, key-word FIFO.
// Optional parity enforcement via PS2_KB_PARITY_CHECK_EN; raw clk fall to kb_ready is about 9 cycles.
module ps2_kb_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic        kb_ack,
    output logic [15:0] kb_data,
    output logic        kb_ready,
    output logic        frame_err,
    output logic        overflow
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic fclk_q, fclk_d, fclk_prev_q, fall_q, fall_d;
    logic [1:0] flt_cnt_q, flt_cnt_d;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            byte_vld_q, byte_vld_d;
    logic            tmo;
`ifdef PS2_KB_PARITY_CHECK_EN
    logic            par_q, par_d;
`endif

    logic            ext_q, ext_d, brk_q, brk_d;
    logic            push;
    logic [15:0]     push_dat;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            pop, full, wr_en;

    // Clock line only changes after four consecutive disagreeing samples.
    always_comb begin
        fclk_d    = fclk_q;
        flt_cnt_d = 2'd0;
        if (clk_s2_q != fclk_q) begin
            if (flt_cnt_q == 2'd3) begin
                fclk_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 2'd1;
            end
        end
        fall_d = fclk_prev_q & ~fclk_q;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        byte_vld_d  = 1'b0;
        tmo         = 1'b0;
`ifdef PS2_KB_PARITY_CHECK_EN
        par_d       = par_q;
`endif
        if (state_q != ST_IDLE) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        if (fall_q) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_KB_PARITY_CHECK_EN
                    par_d = dat_s2_q;
`endif
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
`ifdef PS2_KB_PARITY_CHECK_EN
                    if (dat_s2_q && (^{shift_q, par_q})) begin
`else
                    if (dat_s2_q) begin
`endif
                        byte_vld_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if ((state_q != ST_IDLE) && (to_cnt_d == TW'(TIMEOUT_CYCLES))) begin
            state_d     = ST_IDLE;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
            tmo         = 1'b1;
        end
    end

    // shift_q stays put in IDLE, so it still holds the byte while byte_vld_q is up.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        push_dat = {6'b0, ext_q, brk_q, shift_q};
        if (tmo) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // A pop frees the slot, so a push alongside it is accepted even when full.
    always_comb begin
        pop        = kb_ack && (cnt_q != '0);
        full       = (cnt_q == CW'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            flt_cnt_q   <= 2'd0;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            byte_vld_q  <= 1'b0;
`ifdef PS2_KB_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk_in;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data_in;
            dat_s2_q    <= dat_s1_q;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
            flt_cnt_q   <= flt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
            byte_vld_q  <= byte_vld_d;
`ifdef PS2_KB_PARITY_CHECK_EN
            par_q       <= par_d;
`endif
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign kb_ready  = (cnt_q != '0);
    assign kb_data   = kb_ready ? mem_q[rd_ptr_q] : 16'h0000;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: frames, prefixes, parity, overflow, timeout and mid-frame reset.
module tb_ps2_kb_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic        kb_ack;
    logic [15:0] kb_data;
    logic        kb_ready;
    logic        frame_err;
    logic        overflow;

    int ncmp = 0;
    int nerr = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int ferr_base;
    int lat;

    always #40 clk = ~clk;

    // Count cycles high, so a stretched pulse shows up as an extra count.
    always @(posedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overflow)  ovf_cnt  <= ovf_cnt + 1;
    end

    ps2_kb_rx #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk),
        .ps2_data_in(ps2_dat),
        .kb_ack     (kb_ack),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input int half);
        ps2_dat = b;
        tick(half);
        ps2_clk = 1'b0;
        tick(half);
        ps2_clk = 1'b1;
    endtask

    task automatic frame_head(input logic [7:0] b, input logic badpar, input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit((~^b) ^ badpar, half);
    endtask

    task automatic stop_fall(input int half);
        ps2_dat = 1'b1;
        tick(half);
        ps2_clk = 1'b0;
    endtask

    task automatic stop_rise(input int half);
        tick(half);
        ps2_clk = 1'b1;
        tick(half);
    endtask

    task automatic send(input logic [7:0] b, input logic badpar);
        frame_head(b, badpar, 40);
        stop_fall(40);
        stop_rise(40);
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        chk({tag, "_rdy"}, 32'(kb_ready), 32'd1);
        chk(tag, 32'(kb_data), 32'(exp));
        kb_ack = 1'b1;
        tick(1);
        kb_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        kb_ack  = 1'b0;
        tick(3);
        chk("rst_ready", 32'(kb_ready), 32'd0);
        chk("rst_data", 32'(kb_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick(5);

        // 0x1C at 10 kHz, watching stop-fall to kb_ready latency
        lat = 0;
        frame_head(8'h1C, 1'b0, 625);
        stop_fall(625);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (kb_ready) begin
                lat = i;
                break;
            end
        end
        chk("lat_le_10", 32'((lat >= 1) && (lat <= 10)), 32'd1);
        stop_rise(625);
        chk("w1c_data", 32'(kb_data), 32'h001C);
        kb_ack = 1'b1;
        tick(1);
        kb_ack = 1'b0;
        chk("w1c_empty", 32'(kb_ready), 32'd0);
        chk("w1c_ferr", 32'(ferr_cnt), 32'd0);

        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        chk("prefix_nopush", 32'(kb_ready), 32'd0);
        send(8'h75, 1'b0);
        pop_chk("ext_brk_75", 16'h0375);
        chk("ext_brk_empty", 32'(kb_ready), 32'd0);

        // Falling edge with data high in IDLE is a bad start bit
        ps2_bit(1'b1, 40);
        tick(20);
        chk("bad_start_ferr", 32'(ferr_cnt), 32'd1);

        ferr_base = ferr_cnt;
        send(8'h1C, 1'b1);
`ifdef PS2_KB_PARITY_CHECK_EN
        chk("badpar_ferr", 32'(ferr_cnt), 32'(ferr_base + 1));
        chk("badpar_noword", 32'(kb_ready), 32'd0);
`else
        chk("badpar_ferr", 32'(ferr_cnt), 32'(ferr_base));
        pop_chk("badpar_word", 16'h001C);
`endif

        send(8'h16, 1'b0);
        send(8'h1E, 1'b0);
        send(8'h26, 1'b0);
        send(8'h25, 1'b0);
        chk("fill_noovf", 32'(ovf_cnt), 32'd0);
        send(8'h2E, 1'b0);
        chk("ovf_once", 32'(ovf_cnt), 32'd1);
        pop_chk("ovf_rd1", 16'h0016);
        pop_chk("ovf_rd2", 16'h001E);
        pop_chk("ovf_rd3", 16'h0026);
        pop_chk("ovf_rd4", 16'h0025);
        chk("ovf_drained", 32'(kb_ready), 32'd0);

        // Push lands in the same cycle as kb_ack while full
        send(8'h15, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        frame_head(8'h2C, 1'b0, 40);
        stop_fall(40);
        tick(8);
        kb_ack = 1'b1;
        tick(1);
        kb_ack = 1'b0;
        stop_rise(40);
        chk("coinc_noovf", 32'(ovf_cnt), 32'd1);
        pop_chk("coinc_rd1", 16'h001D);
        pop_chk("coinc_rd2", 16'h0024);
        pop_chk("coinc_rd3", 16'h002D);
        pop_chk("coinc_rd4", 16'h002C);
        chk("coinc_drained", 32'(kb_ready), 32'd0);

        // Timeout after 5 data bits, with a pending E0 that must be cleared
        send(8'hE0, 1'b0);
        ferr_base = ferr_cnt;
        ps2_bit(1'b0, 40);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, 40);
        tick(2100);
        chk("tmo_ferr", 32'(ferr_cnt), 32'(ferr_base + 1));
        chk("tmo_noword", 32'(kb_ready), 32'd0);
        send(8'h29, 1'b0);
        chk("tmo_next_ferr", 32'(ferr_cnt), 32'(ferr_base + 1));
        pop_chk("tmo_next", 16'h0029);

        // Reset in the middle of a frame that follows an E0
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        chk("pre_rst_ready", 32'(kb_ready), 32'd1);
        ps2_bit(1'b0, 40);
        ps2_bit(1'b0, 40);
        ps2_bit(1'b1, 40);
        reset_n = 1'b0;
        tick(2);
        chk("mid_rst_ready", 32'(kb_ready), 32'd0);
        chk("mid_rst_data", 32'(kb_data), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick(5);
        ferr_base = ferr_cnt;
        send(8'h5A, 1'b0);
        pop_chk("post_rst_5a", 16'h005A);
        chk("post_rst_ferr", 32'(ferr_cnt), 32'(ferr_base));
        chk("post_rst_empty", 32'(kb_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
